// File: rtl/mem_responder.sv
// mem_responder: line-granular backing memory for a cache controller.
//   Serves whole-line refills (rd_req) and write-backs (wr_req) after a fixed
//   access latency, one DATA_WIDTH beat per cycle, ascending from line base.
// Ports:
//   clk, reset (sync, active-low)      - clock and reset
//   rd_req / wr_req, req_addr          - request strobes and byte address in the line
//   wr_data, wr_data_valid, wr_data_ready - write-back beat handshake
//   rd_data, rd_data_valid             - refill beats (rd_data is 0 when not valid)
//   mem_ready                          - one-cycle transaction-complete pulse
//   busy                               - high whenever a transaction is in flight
// Every output is a flop; next-cycle values are computed from the next state.

module mem_responder #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_DEPTH     = 1024,
  parameter int LINE_WORDS    = 16,
  parameter int LATENCY       = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rd_req,
  input  logic                     wr_req,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     wr_data_valid,
  output logic                     wr_data_ready,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_data_valid,
  output logic                     mem_ready,
  output logic                     busy
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int OFF_W = $clog2(LINE_WORDS);
  // One extra bit so the counter can represent LINE_WORDS without wrapping.
  localparam int CNT_W = OFF_W + 1;
  localparam int LAT_W = $clog2(LATENCY + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT     = 3'd1,
    RD_BURST = 3'd2,
    WR_BURST = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [IDX_W-1:0] line_base;
  logic             is_write;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] beat_nxt;
  logic [LAT_W-1:0] lat_cnt;

  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] req_base;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx_nxt;
  logic             wr_accept;
  logic             last_beat;

  logic busy_nxt;
  logic mem_ready_nxt;
  logic rd_valid_nxt;
  logic wr_ready_nxt;

  // Only the word-index bits of the byte address matter.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[1:0], req_addr[ADDRESS_WIDTH-1:2+IDX_W]};

  assign req_idx  = req_addr[2 +: IDX_W];
  assign req_base = req_idx & ~IDX_W'(LINE_WORDS - 1);

  // wr_data_ready is a flop mirroring state==WR_BURST, so it is a safe qualifier.
  assign wr_accept = (state == WR_BURST) && wr_data_valid && wr_data_ready;
  assign last_beat = (beat_cnt == CNT_W'(LINE_WORDS - 1));

  assign wr_idx     = line_base + IDX_W'(beat_cnt);
  assign rd_idx_nxt = line_base + IDX_W'(beat_nxt);

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rd_req || wr_req) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (lat_cnt == LAT_W'(LATENCY - 1)) begin
          state_nxt = is_write ? WR_BURST : RD_BURST;
        end
      end
      RD_BURST: begin
        if (last_beat) begin
          state_nxt = DONE;
        end
      end
      WR_BURST: begin
        if (wr_accept && last_beat) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Beat index that will be current after this edge. Reads advance every cycle;
  // writes advance only on an accepted beat, so stalls simply hold the count.
  always_comb begin
    beat_nxt = '0;
    case (state)
      RD_BURST: beat_nxt = beat_cnt + CNT_W'(1);
      WR_BURST: beat_nxt = wr_accept ? beat_cnt + CNT_W'(1) : beat_cnt;
      default:  beat_nxt = '0;
    endcase
  end

  // ---------------------------------------------------------------- outputs (next values)
  always_comb begin
    busy_nxt      = (state_nxt != IDLE);
    mem_ready_nxt = (state_nxt == DONE);
    rd_valid_nxt  = (state_nxt == RD_BURST);
    wr_ready_nxt  = (state_nxt == WR_BURST);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy          <= 1'b0;
      mem_ready     <= 1'b0;
      rd_data_valid <= 1'b0;
      wr_data_ready <= 1'b0;
      rd_data       <= '0;
    end else begin
      busy          <= busy_nxt;
      mem_ready     <= mem_ready_nxt;
      rd_data_valid <= rd_valid_nxt;
      wr_data_ready <= wr_ready_nxt;
      // Fetch the beat for the coming cycle so rd_data lines up with its valid.
      rd_data       <= rd_valid_nxt ? mem[rd_idx_nxt] : '0;
    end
  end

  // ---------------------------------------------------------------- request / counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      line_base <= '0;
      is_write  <= 1'b0;
      lat_cnt   <= '0;
      beat_cnt  <= '0;
    end else begin
      beat_cnt <= beat_nxt;
      case (state)
        IDLE: begin
          lat_cnt <= '0;
          if (rd_req || wr_req) begin
            line_base <= req_base;
            // Write-back wins when both strobes arrive together.
            is_write  <= wr_req;
          end
        end
        WAIT:    lat_cnt <= lat_cnt + LAT_W'(1);
        default: lat_cnt <= '0;
      endcase
    end
  end

  // ---------------------------------------------------------------- storage
  // Never reset: a write-back cut short by reset keeps the beats it landed.
  always_ff @(posedge clk) begin
    if (reset && wr_accept) begin
      mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench for mem_responder with default parameters.
//   Drives requests and write beats 1 ns after each rising edge and samples
//   outputs at the same point; expected values are computed in the bench.

module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rd_req = 1'b0;
  logic        wr_req = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] wr_data = '0;
  logic        wr_data_valid = 1'b0;
  logic        wr_data_ready;
  logic [31:0] rd_data;
  logic        rd_data_valid;
  logic        mem_ready;
  logic        busy;

  int vectors = 0;
  int errors  = 0;

  mem_responder dut (
    .clk           (clk),
    .reset         (reset),
    .rd_req        (rd_req),
    .wr_req        (wr_req),
    .req_addr      (req_addr),
    .wr_data       (wr_data),
    .wr_data_valid (wr_data_valid),
    .wr_data_ready (wr_data_ready),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .mem_ready     (mem_ready),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write-back of one line: beat i carries dbase+i. Optional 3-cycle valid
  // stall after beat 6. exp_done = edges from acceptance to mem_ready.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] dbase,
                          input bit also_rd, input int stall_max, input int exp_done);
    int  beat, n, first_rdy, done_n, stalls, rd_seen;
    bit  r, v;
    wr_req   = 1'b1;
    rd_req   = also_rd;
    req_addr = addr;
    tick();
    wr_req = 1'b0;
    rd_req = 1'b0;
    check("wr_busy_at_accept", 32'(busy), 32'd1);
    beat = 0; n = 0; first_rdy = -1; done_n = -1; stalls = 0; rd_seen = 0;
    wr_data_valid = 1'b1;
    wr_data       = dbase;
    for (int k = 0; k < 60 && done_n < 0; k++) begin
      r = wr_data_ready;
      v = wr_data_valid;
      tick();
      n++;
      if (r && v) beat++;
      if (wr_data_ready && first_rdy < 0) first_rdy = n;
      if (rd_data_valid) rd_seen = 1;
      if (mem_ready) done_n = n;
      if (beat == 7 && stalls < stall_max) begin
        wr_data_valid = 1'b0;
        stalls++;
      end else begin
        wr_data_valid = (beat < 16);
      end
      wr_data = dbase + 32'(beat);
    end
    wr_data_valid = 1'b0;
    check("wr_ready_rise", 32'(first_rdy), 32'd4);
    check("wr_beats", 32'(beat), 32'd16);
    check("wr_done_cycle", 32'(done_n), 32'(exp_done));
    check("wr_no_rd_valid", 32'(rd_seen), 32'd0);
    tick();
    check("wr_ready_pulse_once", 32'(mem_ready), 32'd0);
    check("wr_idle_busy", 32'(busy), 32'd0);
  endtask

  // Refill of one line, expecting beat i == dbase+i. If abort_beat >= 0, reset
  // is asserted during the cycle that shows that beat.
  task automatic do_read(input logic [31:0] addr, input logic [31:0] dbase, input int abort_beat);
    int n, beats, first_v, done_n, busy_cnt, wr_seen, aborted;
    rd_req   = 1'b1;
    req_addr = addr;
    tick();
    rd_req = 1'b0;
    check("rd_busy_at_accept", 32'(busy), 32'd1);
    busy_cnt = 1; n = 0; beats = 0; first_v = -1; done_n = -1; wr_seen = 0; aborted = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      n++;
      if (!busy) break;
      busy_cnt++;
      if (rd_data_valid) begin
        check("rd_beat", rd_data, dbase + 32'(beats));
        if (first_v < 0) first_v = n;
        beats++;
      end else begin
        check("rd_data_zero", rd_data, 32'd0);
      end
      if (wr_data_ready) wr_seen = 1;
      if (mem_ready) done_n = n;
      if (abort_beat >= 0 && beats == abort_beat + 1) begin
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort_rd_valid", 32'(rd_data_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_mem_ready", 32'(mem_ready), 32'd0);
        check("abort_rd_data", rd_data, 32'd0);
        tick();
        check("abort_still_idle", 32'({busy, mem_ready}), 32'd0);
        aborted = 1;
        break;
      end
    end
    check("rd_no_wr_ready", 32'(wr_seen), 32'd0);
    if (!aborted) begin
      check("rd_first_valid", 32'(first_v), 32'd4);
      check("rd_beats", 32'(beats), 32'd16);
      check("rd_done_cycle", 32'(done_n), 32'd20);
      // 4 WAIT + 16 RD_BURST + 1 DONE
      check("rd_busy_len", 32'(busy_cnt), 32'd21);
    end
  endtask

  initial begin
    // Reset held for two edges with rd_req high.
    reset  = 1'b0;
    rd_req = 1'b1;
    tick();
    check("rst1_outs", 32'({busy, mem_ready, rd_data_valid, wr_data_ready}), 32'd0);
    check("rst1_rd_data", rd_data, 32'd0);
    tick();
    check("rst2_outs", 32'({busy, mem_ready, rd_data_valid, wr_data_ready}), 32'd0);
    check("rst2_rd_data", rd_data, 32'd0);
    reset  = 1'b1;
    rd_req = 1'b0;
    tick();
    check("post_rst_busy0", 32'(busy), 32'd0);
    tick();
    check("post_rst_busy1", 32'(busy), 32'd0);

    // Write-back of line at word 80, then refill through an offset address.
    do_write(32'h140, 32'hA000_0000, 1'b0, 0, 20);
    do_read(32'h17C, 32'hA000_0000, -1);

    // Simultaneous rd+wr: write-back only; rd_req dropped, so nothing follows.
    do_write(32'h000, 32'hB000_0000, 1'b1, 0, 20);
    tick();
    check("both_no_read_after", 32'(busy), 32'd0);

    // Write-back with a 3-cycle valid stall after beat 6.
    do_write(32'h200, 32'hC000_0000, 1'b0, 3, 23);
    do_read(32'h200, 32'hC000_0000, -1);
    do_read(32'h004, 32'hB000_0000, -1);

    // Reset during read beat 5, then a fresh refill of the same line.
    do_read(32'h140, 32'hA000_0000, 5);
    do_read(32'h140, 32'hA000_0000, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
